// File: rtl/sar_pkg.sv
// Shared definitions for the SAR code collector: default resolution,
// phase-FSM state encodings and a one-hot helper.
package sar_pkg;

  localparam int unsigned SAR_NBITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_BIT   = 2'd2,
    ST_LAST  = 2'd3
  } coll_state_e;

  function automatic logic is_one_hot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/sar_code_fifo.sv
// First-word fall-through code FIFO with a registered head word and
// wrap-bit pointers; a push while full is accepted only alongside a pop.
module sar_code_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] data_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic             push_ok, pop_ok;

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign wr_nxt  = wr_ptr + PW'(push_ok);
  assign rd_nxt  = rd_ptr + PW'(pop_ok);

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= data_in;
  end

  // Head register bypasses storage when the new head is the word written this edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      data_out <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      empty  <= (wr_nxt == rd_nxt);
      full   <= (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]) && (wr_nxt[AW] != rd_nxt[AW]);
      if (wr_nxt != rd_nxt) begin
        data_out <= (push_ok && (rd_nxt == wr_ptr)) ? data_in : mem[rd_nxt[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/sar_code_collector.sv
// Collects per-phase comparator decisions into conversion codes, checks the
// phase sequence and queues finished codes for the back-end.
module sar_code_collector
  import sar_pkg::*;
#(
  parameter int unsigned NBITS = SAR_NBITS,
  parameter int unsigned DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SAR_RESET,
  input  logic [NBITS-2:0] OUTEN,
  input  logic             VCOMP,
  output logic [NBITS-1:0] DOUT,
  output logic             DOUT_VALID,
  input  logic             DOUT_READY,
  output logic             SEQ_ERR,
  output logic             OVERRUN,
  output logic [7:0]       CONV_CNT
);

  localparam int unsigned OW = NBITS - 1;
  localparam int unsigned KW = $clog2(NBITS);

  coll_state_e   state, state_nxt;
  logic [KW-1:0] bit_k;
  logic [OW-1:0] code_q;
  logic [OW-1:0] exp_c;
  logic          phase_ok_c;
  logic          capture_c, push_c, seq_err_c;
  logic          fifo_full, fifo_empty, pop;

  // bit_k is the code bit captured in ARMED/BIT; its enable is OUTEN[bit_k-1].
  assign exp_c      = OW'(1) << (bit_k - KW'(1));
  assign phase_ok_c = is_one_hot(32'(OUTEN)) && (OUTEN == exp_c);
  assign pop        = DOUT_VALID & DOUT_READY;
  assign DOUT_VALID = ~fifo_empty;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (SAR_RESET) begin
      state_nxt = ST_ARMED;
    end else begin
      case (state)
        ST_ARMED, ST_BIT: begin
          if (!phase_ok_c)          state_nxt = ST_IDLE;
          else if (bit_k == KW'(1)) state_nxt = ST_LAST;
          else                      state_nxt = ST_BIT;
        end
        ST_LAST: state_nxt = ST_IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    capture_c = 1'b0;
    push_c    = 1'b0;
    seq_err_c = 1'b0;
    if (!SAR_RESET) begin
      case (state)
        ST_ARMED, ST_BIT: begin
          capture_c = phase_ok_c;
          seq_err_c = ~phase_ok_c;
        end
        ST_LAST: begin
          push_c    = (OUTEN == '0);
          seq_err_c = (OUTEN != '0);
        end
        default: ;
      endcase
    end
  end

  // Upper code bits, error pulse, sticky overrun and push counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      code_q   <= '0;
      bit_k    <= KW'(NBITS - 1);
      SEQ_ERR  <= 1'b0;
      OVERRUN  <= 1'b0;
      CONV_CNT <= 8'd0;
    end else begin
      SEQ_ERR <= seq_err_c;
      if (SAR_RESET) begin
        code_q <= '0;
        bit_k  <= KW'(NBITS - 1);
      end else if (capture_c) begin
        if (VCOMP) code_q <= code_q | exp_c;
        bit_k <= bit_k - KW'(1);
      end
      if (push_c && fifo_full && !pop)    OVERRUN  <= 1'b1;
      if (push_c && (!fifo_full || pop)) CONV_CNT <= CONV_CNT + 8'd1;
    end
  end

  sar_code_fifo #(
    .WIDTH (NBITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RESET    (RESET),
    .push     (push_c),
    .data_in  ({code_q, VCOMP}),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .data_out (DOUT)
  );

endmodule

// File: tb/tb_sar_code_collector.sv
// Randomized and directed bench for sar_code_collector against a
// phase-counting reference model with a queue-based FIFO.
module tb_sar_code_collector;

  localparam int NB    = 4;
  localparam int DEPTH = 4;

  logic          CLK;
  logic          RESET;
  logic          SAR_RESET;
  logic [NB-2:0] OUTEN;
  logic          VCOMP;
  logic [NB-1:0] DOUT;
  logic          DOUT_VALID;
  logic          DOUT_READY;
  logic          SEQ_ERR;
  logic          OVERRUN;
  logic [7:0]    CONV_CNT;

  int n_tests = 0;
  int n_fail  = 0;
  bit rdy_rand = 1'b0;

  // reference model state
  int q[$];
  bit m_active = 1'b0;
  int m_done   = 0;
  int m_code   = 0;
  bit m_complete = 1'b0;
  bit m_err    = 1'b0;
  bit m_ovr    = 1'b0;
  int m_cnt    = 0;
  int m_dout   = 0;

  sar_code_collector #(.NBITS(NB), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .SAR_RESET  (SAR_RESET),
    .OUTEN      (OUTEN),
    .VCOMP      (VCOMP),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .DOUT_READY (DOUT_READY),
    .SEQ_ERR    (SEQ_ERR),
    .OVERRUN    (OVERRUN),
    .CONV_CNT   (CONV_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: count captured phases, then a plain queue stands in for the FIFO.
  initial forever begin
    @(posedge CLK or posedge RESET);
    if (RESET) begin
      q.delete();
      m_active = 1'b0; m_done = 0; m_code = 0; m_err = 1'b0;
      m_ovr = 1'b0; m_cnt = 0; m_dout = 0;
    end else begin
      m_complete = 1'b0;
      m_err      = 1'b0;
      if (SAR_RESET) begin
        m_active = 1'b1; m_done = 0; m_code = 0;
      end else if (m_active) begin
        m_active = 1'b0;
        if (m_done < NB - 1) begin
          if (int'(OUTEN) == (1 << (NB - 2 - m_done))) begin
            m_code   = m_code | (int'(VCOMP) << (NB - 1 - m_done));
            m_done   = m_done + 1;
            m_active = 1'b1;
          end else begin
            m_err = 1'b1;
          end
        end else if (OUTEN == '0) begin
          m_code     = m_code | int'(VCOMP);
          m_complete = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
      if (q.size() > 0 && DOUT_READY) void'(q.pop_front());
      if (m_complete) begin
        if (q.size() < DEPTH) begin
          q.push_back(m_code);
          m_cnt = (m_cnt + 1) % 256;
        end else begin
          m_ovr = 1'b1;
        end
      end
      if (q.size() > 0) m_dout = q[0];
    end
  end

  initial forever begin
    @(negedge CLK);
    check("valid", int'(DOUT_VALID), int'(q.size() > 0));
    check("dout", int'(DOUT), m_dout);
    check("seq_err", int'(SEQ_ERR), int'(m_err));
    check("overrun", int'(OVERRUN), int'(m_ovr));
    check("conv_cnt", int'(CONV_CNT), m_cnt);
  end

  task automatic drive(input bit sr, input logic [NB-2:0] oe, input bit vc);
    @(negedge CLK);
    #1;
    SAR_RESET = sr;
    OUTEN     = oe;
    VCOMP     = vc;
    if (rdy_rand) DOUT_READY = 1'($urandom_range(0, 1));
  endtask

  task automatic conv(input logic [NB-1:0] code, input bit rdy_last);
    drive(1'b1, '0, 1'b0);
    for (int k = NB - 1; k >= 1; k--) drive(1'b0, (NB-1)'(1 << (k - 1)), code[k]);
    drive(1'b0, '0, code[0]);
    if (rdy_last) DOUT_READY = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #1;
    RESET = 1'b1; SAR_RESET = 1'b0; OUTEN = '0; VCOMP = 1'b0; DOUT_READY = 1'b0;
    @(negedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  // Call at a negedge with the head already on DOUT.
  task automatic expect_drain(input logic [15:0] codes);
    DOUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_dout", int'(DOUT), int'(codes[15 - 4*i -: 4]));
      check("drain_valid", int'(DOUT_VALID), 1);
      @(negedge CLK);
    end
    DOUT_READY = 1'b0;
    check("drain_empty", int'(DOUT_VALID), 0);
  endtask

  initial begin
    RESET = 1'b1; SAR_RESET = 1'b0; OUTEN = '0; VCOMP = 1'b0; DOUT_READY = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_dout", int'(DOUT), 0);
    check("rst_valid", int'(DOUT_VALID), 0);
    check("rst_seq_err", int'(SEQ_ERR), 0);
    check("rst_overrun", int'(OVERRUN), 0);
    check("rst_cnt", int'(CONV_CNT), 0);
    #1 RESET = 1'b0;

    // nominal conversion
    conv(4'b1011, 1'b0);
    @(negedge CLK);
    check("t1_dout", int'(DOUT), 11);
    check("t1_valid", int'(DOUT_VALID), 1);
    check("t1_cnt", int'(CONV_CNT), 1);

    // back-to-back with overrun
    do_reset();
    conv(4'h0, 1'b0); conv(4'hF, 1'b0); conv(4'h5, 1'b0); conv(4'hA, 1'b0); conv(4'h3, 1'b0);
    @(negedge CLK);
    check("t2_overrun", int'(OVERRUN), 1);
    check("t2_cnt", int'(CONV_CNT), 4);
    expect_drain(16'h0F5A);
    check("t2_hold", int'(DOUT), 10);

    // sequence error then clean conversion
    do_reset();
    drive(1'b1, '0, 1'b0);
    drive(1'b0, 3'b100, 1'b1);
    drive(1'b0, 3'b001, 1'b0);
    @(negedge CLK);
    check("t3_seq_err", int'(SEQ_ERR), 1);
    check("t3_nopush", int'(DOUT_VALID), 0);
    @(negedge CLK);
    check("t3_pulse_end", int'(SEQ_ERR), 0);
    conv(4'b0110, 1'b0);
    @(negedge CLK);
    check("t3_dout", int'(DOUT), 6);
    check("t3_cnt", int'(CONV_CNT), 1);

    // full FIFO with simultaneous push and pop
    do_reset();
    conv(4'h1, 1'b0); conv(4'h2, 1'b0); conv(4'h3, 1'b0); conv(4'h4, 1'b0);
    conv(4'h6, 1'b1);
    @(negedge CLK);
    DOUT_READY = 1'b0;
    check("t4_overrun", int'(OVERRUN), 0);
    check("t4_cnt", int'(CONV_CNT), 5);
    expect_drain(16'h2346);

    // abort mid-conversion, then RESET with codes queued
    do_reset();
    drive(1'b1, '0, 1'b0);
    drive(1'b0, 3'b100, 1'b1);
    drive(1'b0, 3'b010, 1'b1);
    drive(1'b1, '0, 1'b0);
    drive(1'b0, 3'b100, 1'b0);
    drive(1'b0, 3'b010, 1'b1);
    drive(1'b0, 3'b001, 1'b0);
    drive(1'b0, 3'b000, 1'b1);
    @(negedge CLK);
    check("t5_dout", int'(DOUT), 5);
    check("t5_cnt", int'(CONV_CNT), 1);
    check("t5_seq_err", int'(SEQ_ERR), 0);
    conv(4'h9, 1'b0);
    @(negedge CLK);
    check("t5_queued", int'(CONV_CNT), 2);
    #1 RESET = 1'b1;
    @(negedge CLK);
    check("t5_rst_dout", int'(DOUT), 0);
    check("t5_rst_valid", int'(DOUT_VALID), 0);
    check("t5_rst_cnt", int'(CONV_CNT), 0);
    #1 RESET = 1'b0;

    // non-one-hot enable in ARMED
    do_reset();
    drive(1'b1, '0, 1'b0);
    drive(1'b0, 3'b110, 1'b1);
    @(negedge CLK);
    check("t6_seq_err", int'(SEQ_ERR), 1);
    drive(1'b0, 3'b100, 1'b1);
    drive(1'b0, 3'b000, 1'b1);
    @(negedge CLK);
    check("t6_idle_valid", int'(DOUT_VALID), 0);
    check("t6_idle_err", int'(SEQ_ERR), 0);

    // randomized traffic
    rdy_rand = 1'b1;
    for (int it = 0; it < 300; it++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 11) begin
        conv(4'($urandom), 1'b0);
      end else if (r < 14) begin
        for (int c = 0; c < int'($urandom_range(1, 4)); c++)
          drive($urandom_range(0, 3) == 0, 3'($urandom), 1'($urandom));
      end else if (r < 16) begin
        drive(1'b1, '0, 1'b0);
        drive(1'b0, 3'b100, 1'($urandom));
        drive(1'b0, 3'($urandom), 1'($urandom));
        drive(1'b0, 3'($urandom_range(0, 1)), 1'($urandom));
      end else if (r < 19) begin
        drive(1'b0, 3'($urandom), 1'($urandom));
      end else begin
        do_reset();
      end
    end
    rdy_rand = 1'b0;
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
